// File: rtl/slice_reader.sv
// rtl/slice_reader.sv - streams RGB565 slices from the slice RAM to the LED driver through a skid FIFO.
// Optional SLICE_READER_RESYNC_EN: slice_start during READ/DRAIN drops the partial slice and restarts.
module slice_reader #(
  parameter int RAM_ADDR_WIDTH = 32,
  parameter int RAM_DATA_WIDTH = 16,
  parameter int IMAGE_IN_RAM   = 18,
  parameter int IMAGE_WIDTH    = 40,
  parameter int IMAGE_HEIGHT   = 48,
  parameter int RAM_LATENCY    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stream_ready,
  input  logic                      slice_start,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
  output logic                      ram_rd_en,
  input  logic [RAM_DATA_WIDTH-1:0] ram_rd_data,
  output logic [RAM_DATA_WIDTH-1:0] px_data,
  output logic                      px_valid,
  input  logic                      px_ready,
  output logic                      px_first,
  output logic                      px_last,
  output logic [4:0]                slice_idx,
  output logic                      overrun
);
  localparam int IMAGE_SIZE = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int FIFO_DEPTH = RAM_LATENCY + 2;
  localparam int PW = $clog2(IMAGE_SIZE + 1);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam logic [PW-1:0] PIX_LAST = PW'(IMAGE_SIZE - 1);
  localparam logic [4:0] IDX_LAST = 5'(IMAGE_IN_RAM - 1);
  localparam logic [RAM_ADDR_WIDTH-1:0] SLICE_SPAN = RAM_ADDR_WIDTH'(IMAGE_SIZE);
  localparam logic [FW-1:0] PTR_LAST = FW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READ, S_DRAIN} state_t;

  state_t                      state;
  logic [RAM_ADDR_WIDTH-1:0]   slice_base;
  logic [PW-1:0]               pix_rd;
  logic [PW-1:0]               pix_out;
  logic [RAM_LATENCY-1:0]      pipe;
  logic [RAM_DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
  logic [FW-1:0]               wr_ptr, rd_ptr;
  logic [CW-1:0]               fifo_count, fifo_next;
  // pending = reads in flight + words held in the FIFO
  logic [CW-1:0]               pending;

  logic pop, push, busy, start_ok, resync, flush, room, issue, last_pop;
  logic [4:0]                  idx_next;
  logic [RAM_ADDR_WIDTH-1:0]   base_next;

  always_comb begin
    pop       = px_valid && px_ready;
    push      = pipe[RAM_LATENCY-1];
    busy      = (state == S_READ) || (state == S_DRAIN);
    start_ok  = stream_ready && slice_start && (state == S_WAIT);
`ifdef SLICE_READER_RESYNC_EN
    resync    = stream_ready && slice_start && busy;
`else
    resync    = 1'b0;
`endif
    flush     = !stream_ready || resync;
    room      = (pending - CW'(pop)) < DEPTH_C;
    issue     = !flush && (start_ok || ((state == S_READ) && room));
    last_pop  = pop && (pix_out == PIX_LAST);
    idx_next  = (slice_idx == IDX_LAST) ? 5'd0 : slice_idx + 5'd1;
    base_next = (slice_idx == IDX_LAST) ? '0 : slice_base + SLICE_SPAN;
    fifo_next = fifo_count + CW'(push) - CW'(pop);
  end

  assign px_data  = mem[rd_ptr];
  assign px_first = px_valid && (pix_out == '0);
  assign px_last  = px_valid && (pix_out == PIX_LAST);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= ram_rd_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      ram_addr   <= '0;
      ram_rd_en  <= 1'b0;
      px_valid   <= 1'b0;
      slice_idx  <= '0;
      slice_base <= '0;
      overrun    <= 1'b0;
      pix_rd     <= '0;
      pix_out    <= '0;
      pipe       <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      pending    <= '0;
    end else begin
      ram_rd_en <= issue;
      if (issue) begin
        ram_addr <= slice_base + RAM_ADDR_WIDTH'(pix_rd);
        pix_rd   <= pix_rd + 1'b1;
      end
      if (stream_ready && slice_start && busy) overrun <= 1'b1;

      // Flush discards the strobe currently on the bus as well as older ones.
      if (flush) begin
        pipe       <= '0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_count <= '0;
        pending    <= '0;
        px_valid   <= 1'b0;
        pix_out    <= '0;
        pix_rd     <= '0;
      end else begin
        pipe[0] <= ram_rd_en;
        for (int i = 1; i < RAM_LATENCY; i++) pipe[i] <= pipe[i-1];
        if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
        if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
        fifo_count <= fifo_next;
        px_valid   <= (fifo_next != '0);
        pending    <= pending + CW'(issue) - CW'(pop);
        if (pop) pix_out <= last_pop ? '0 : pix_out + 1'b1;
      end

      if (!stream_ready) begin
        state <= S_IDLE;
      end else if (resync) begin
        state      <= S_READ;
        slice_idx  <= idx_next;
        slice_base <= base_next;
      end else begin
        case (state)
          S_IDLE:  state <= S_WAIT;
          S_WAIT:  if (slice_start) state <= (pix_rd == PIX_LAST) ? S_DRAIN : S_READ;
          S_READ:  if (issue && (pix_rd == PIX_LAST)) state <= S_DRAIN;
          S_DRAIN: if (last_pop) begin
            state      <= S_WAIT;
            slice_idx  <= idx_next;
            slice_base <= base_next;
            pix_rd     <= '0;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_slice_reader.sv
// tb/tb_slice_reader.sv - directed bench for slice_reader with a latency-4 RAM model.
module tb_slice_reader;
  localparam int LAT = 4;
  localparam int SZ  = 1920;
`ifdef SLICE_READER_RESYNC_EN
  localparam int T4_IDX = 2;
  localparam int T4_LAST = 3839;
  localparam bit T4_JUMP = 1'b1;
`else
  localparam int T4_IDX = 1;
  localparam int T4_LAST = 1919;
  localparam bit T4_JUMP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stream_ready = 1'b0;
  logic        slice_start = 1'b0;
  logic [31:0] ram_addr;
  logic        ram_rd_en;
  logic [15:0] ram_rd_data;
  logic [15:0] px_data;
  logic        px_valid;
  logic        px_ready = 1'b1;
  logic        px_first, px_last;
  logic [4:0]  slice_idx;
  logic        overrun;

  slice_reader #(.RAM_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .stream_ready(stream_ready), .slice_start(slice_start),
    .ram_addr(ram_addr), .ram_rd_en(ram_rd_en), .ram_rd_data(ram_rd_data),
    .px_data(px_data), .px_valid(px_valid), .px_ready(px_ready),
    .px_first(px_first), .px_last(px_last), .slice_idx(slice_idx), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // RAM returns addr[15:0], valid LAT cycles after the strobe
  logic [15:0] ram_pipe [LAT];
  always @(posedge clk) begin
    ram_pipe[0] <= ram_addr[15:0];
    for (int i = 1; i < LAT; i++) ram_pipe[i] <= ram_pipe[i-1];
  end
  assign ram_rd_data = ram_pipe[LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0, fails = 0;
  logic mon_clr = 1'b0, allow_jump = 1'b0;
  int exp_start = 0;
  int acc, next_exp, seq_err, flag_err, issued, popped, max_out, first_data, last_data;
  int first_cycle, last_cycle;
  bit jumped;

  always @(negedge clk) begin
    if (mon_clr) begin
      acc = 0; next_exp = exp_start; seq_err = 0; flag_err = 0;
      issued = 0; popped = 0; max_out = 0; jumped = 0;
    end else if (!rst) begin
      issued += int'(ram_rd_en);
      if (issued - popped > max_out) max_out = issued - popped;
      if (px_valid && px_ready) begin
        if (int'(px_data) != next_exp) begin
          if (allow_jump && !jumped && px_data == 16'd1920) jumped = 1;
          else seq_err++;
        end
        if (px_first != ((int'(px_data) % SZ) == 0)) flag_err++;
        if (px_last != ((int'(px_data) % SZ) == SZ - 1)) flag_err++;
        if (acc == 0) begin first_data = int'(px_data); first_cycle = cyc; end
        last_data = int'(px_data);
        last_cycle = cyc;
        next_exp = int'(px_data) + 1;
        acc++;
        popped++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon(input int start);
    exp_start = start;
    mon_clr = 1'b1;
    tick();
    mon_clr = 1'b0;
  endtask

  task automatic pulse_start();
    slice_start = 1'b1;
    tick();
    slice_start = 1'b0;
  endtask

  task automatic wait_idx(input int idx, input int max, input bit rnd, input string tag);
    int n = 0;
    while (slice_idx != 5'(idx) && n < max) begin
      if (rnd) px_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    px_ready = 1'b1;
    if (n >= max) check(tag, 0, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_en"}, 32'(ram_rd_en), 0);
    check({tag, "_addr"}, ram_addr, 0);
    check({tag, "_valid"}, 32'(px_valid), 0);
    check({tag, "_first"}, 32'(px_first), 0);
    check({tag, "_last"}, 32'(px_last), 0);
    check({tag, "_idx"}, 32'(slice_idx), 0);
    check({tag, "_overrun"}, 32'(overrun), 0);
  endtask

  initial begin
    int n;
    repeat (2) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // single slice: latency, order, flags, rate
    stream_ready = 1'b1;
    tick(); tick();
    clear_mon(0);
    pulse_start();
    n = 1;
    while (!px_valid && n < 50) begin tick(); n++; end
    check("latency", n, LAT + 2);
    wait_idx(1, 4000, 0, "t1_timeout");
    check("t1_count", acc, SZ);
    check("t1_order", seq_err, 0);
    check("t1_flags", flag_err, 0);
    check("t1_first", first_data, 0);
    check("t1_last", last_data, SZ - 1);
    check("t1_rate", last_cycle - first_cycle, SZ - 1);
    check("t1_idx", 32'(slice_idx), 1);

    // remaining 17 slices and wrap
    clear_mon(SZ);
    for (int s = 1; s < 18; s++) begin
      pulse_start();
      wait_idx((s + 1) % 18, 4000, 0, "t2_timeout");
    end
    check("t2_count", acc, 17 * SZ);
    check("t2_order", seq_err, 0);
    check("t2_flags", flag_err, 0);
    check("t2_last", last_data, 34559);
    check("t2_wrap", 32'(slice_idx), 0);
    check("t2_overrun", 32'(overrun), 0);

    // slice_start while busy
    clear_mon(0);
    allow_jump = T4_JUMP;
    pulse_start();
    repeat (1000) tick();
    pulse_start();
    check("t4_overrun", 32'(overrun), 1);
    wait_idx(T4_IDX, 5000, 0, "t4_timeout");
    allow_jump = 1'b0;
    check("t4_order", seq_err, 0);
    check("t4_last", last_data, T4_LAST);
    check("t4_jump", 32'(jumped), 32'(T4_JUMP));
    if (!T4_JUMP) check("t4_count", acc, SZ);

    // stream_ready dropped mid-slice, then restart same slice
    pulse_start();
    repeat (500) tick();
    stream_ready = 1'b0;
    tick();
    check("t5_valid", 32'(px_valid), 0);
    check("t5_rd_en", 32'(ram_rd_en), 0);
    tick();
    check("t5_idx_kept", 32'(slice_idx), T4_IDX);
    stream_ready = 1'b1;
    tick(); tick();
    clear_mon(T4_IDX * SZ);
    pulse_start();
    wait_idx(T4_IDX + 1, 4000, 0, "t5_timeout");
    check("t5_count", acc, SZ);
    check("t5_order", seq_err, 0);
    check("t5_first", first_data, T4_IDX * SZ);

    // random back-pressure
    clear_mon((T4_IDX + 1) * SZ);
    pulse_start();
    wait_idx(T4_IDX + 2, 12000, 1, "t3_timeout");
    check("t3_count", acc, SZ);
    check("t3_order", seq_err, 0);
    check("t3_flags", flag_err, 0);
    check("t3_outstanding", 32'(max_out <= LAT + 2), 1);

    // async reset mid-read
    pulse_start();
    n = 0;
    while (!px_valid && n < 50) begin tick(); n++; end
    check("t6_valid_before", 32'(px_valid), 1);
    #2 rst = 1'b1;
    #1 check_reset_outputs("t6");
    tick();
    rst = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
